// File: rtl/drive_cmd_ctrl.sv
// drive_cmd_ctrl: IR-commanded drive controller with proximity obstacle
// detection, a deadman command timeout and periodic 4-byte UART telemetry.
//
// Build option: define DRIVE_OBSTACLE_STOP_EN to let the obstacle flag turn
// forward motion into brake. Without it, blocked is only reported.
//
// Telemetry FSM
//   state  | meaning
//   T_IDLE | no packet in flight; waits for a period tick or a pending request
//   T_HDR  | presenting header byte 0xA5
//   T_STAT | presenting status snapshot {blocked, cmd_timeout, 000, motor_state}
//   T_DIST | presenting saturated min-distance snapshot
//   T_SUM  | presenting XOR checksum of the three previous bytes
module drive_cmd_ctrl #(
    parameter int NUM_PROX    = 2,
    parameter int DIST_W      = 8,
    parameter int STOP_DIST   = 20,
    parameter int CMD_TIMEOUT = 25_000_000,
    parameter int TLM_PERIOD  = 500_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ir_valid,
    input  logic [31:0]                ir_data,
    input  logic [NUM_PROX-1:0]        prox_valid,
    input  logic [NUM_PROX*DIST_W-1:0] prox_dist,
    output logic [2:0]                 motor_state,
    output logic                       blocked,
    output logic                       cmd_timeout,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready
);

    localparam int TO_W  = $clog2(CMD_TIMEOUT);
    localparam int PER_W = $clog2(TLM_PERIOD);

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_FWD   = 3'd1;
    localparam logic [2:0] M_LEFT  = 3'd2;
    localparam logic [2:0] M_BRAKE = 3'd3;
    localparam logic [2:0] M_RIGHT = 3'd4;
    localparam logic [2:0] M_REV   = 3'd5;

    localparam logic [7:0]        HDR_BYTE = 8'hA5;
    localparam logic [DIST_W-1:0] STOP_V   = DIST_W'(STOP_DIST);

    typedef enum logic [2:0] {T_IDLE, T_HDR, T_STAT, T_DIST, T_SUM} tlm_state_t;

    logic [7:0]        key;
    logic              frame_ok;
    logic [2:0]        key_state;
    logic [2:0]        req_state;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit;
    logic [DIST_W-1:0] chan_dist [NUM_PROX];
    logic [DIST_W-1:0] min_next;
    logic [DIST_W-1:0] min_dist;
    logic [7:0]        dist_byte;
    logic [7:0]        stat_byte;
    logic [PER_W-1:0]  per_cnt;
    logic              tick;
    tlm_state_t        tlm_state;
    logic [7:0]        stat_snap;
    logic [7:0]        dist_snap;
    logic              pending;
    logic              tx_hs;
    logic              unused_ir;

    // Low half of the IR frame carries the address, which this block ignores.
    assign unused_ir = ^ir_data[15:0];

    assign key      = ir_data[23:16];
    assign frame_ok = ir_valid && (ir_data[31:24] == ~key);

    // Key to motion decode; unknown keys stop the drive.
    always_comb begin
        case (key)
            8'h02:   key_state = M_FWD;
            8'h04:   key_state = M_LEFT;
            8'h05:   key_state = M_BRAKE;
            8'h06:   key_state = M_RIGHT;
            8'h08:   key_state = M_REV;
            default: key_state = M_IDLE;
        endcase
    end

    // Forward requests are converted to brake while an obstacle is present.
    always_comb begin
        req_state = key_state;
`ifdef DRIVE_OBSTACLE_STOP_EN
        if (key_state == M_FWD && blocked) begin
            req_state = M_BRAKE;
        end
`endif
    end

    // Deadman counter: clears on every accepted frame, parks at terminal count.
    assign to_hit = (to_cnt == TO_W'(CMD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (frame_ok) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Motion state: a fresh frame beats a simultaneous timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motor_state <= M_IDLE;
            cmd_timeout <= 1'b0;
        end else if (frame_ok) begin
            motor_state <= req_state;
            cmd_timeout <= 1'b0;
        end else if (to_hit) begin
            motor_state <= M_IDLE;
            cmd_timeout <= 1'b1;
        end
`ifdef DRIVE_OBSTACLE_STOP_EN
        else if (motor_state == M_FWD && blocked) begin
            motor_state <= M_BRAKE;
        end
`endif
    end

    // Per-channel distance capture; all-ones means "nothing seen yet".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PROX; i++) begin
                chan_dist[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NUM_PROX; i++) begin
                if (prox_valid[i]) begin
                    chan_dist[i] <= prox_dist[i*DIST_W +: DIST_W];
                end
            end
        end
    end

    // Nearest obstacle across all channels.
    always_comb begin
        min_next = chan_dist[0];
        for (int i = 1; i < NUM_PROX; i++) begin
            if (chan_dist[i] < min_next) begin
                min_next = chan_dist[i];
            end
        end
    end

    // Two-stage pipeline: registered minimum, then registered threshold flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_dist <= '1;
            blocked  <= 1'b0;
        end else begin
            min_dist <= min_next;
            blocked  <= (min_dist < STOP_V);
        end
    end

    if (DIST_W > 8) begin : g_dist_sat
        assign dist_byte = (|min_dist[DIST_W-1:8]) ? 8'hFF : min_dist[7:0];
    end else begin : g_dist_ext
        assign dist_byte = 8'(min_dist);
    end

    assign stat_byte = {blocked, cmd_timeout, 3'b000, motor_state};

    // Free-running telemetry period counter.
    assign tick = (per_cnt == PER_W'(TLM_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
        end else if (tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    assign tx_hs = tx_valid && tx_ready;

    // Telemetry packet sequencer; a tick during a packet is remembered once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlm_state <= T_IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            stat_snap <= 8'h00;
            dist_snap <= 8'h00;
            pending   <= 1'b0;
        end else begin
            case (tlm_state)
                T_IDLE: begin
                    if (tick || pending) begin
                        tlm_state <= T_HDR;
                        tx_valid  <= 1'b1;
                        tx_data   <= HDR_BYTE;
                        stat_snap <= stat_byte;
                        dist_snap <= dist_byte;
                        pending   <= 1'b0;
                    end
                end
                T_HDR: begin
                    if (tx_hs) begin
                        tlm_state <= T_STAT;
                        tx_data   <= stat_snap;
                    end
                end
                T_STAT: begin
                    if (tx_hs) begin
                        tlm_state <= T_DIST;
                        tx_data   <= dist_snap;
                    end
                end
                T_DIST: begin
                    if (tx_hs) begin
                        tlm_state <= T_SUM;
                        tx_data   <= HDR_BYTE ^ stat_snap ^ dist_snap;
                    end
                end
                T_SUM: begin
                    if (tx_hs) begin
                        tlm_state <= T_IDLE;
                        tx_valid  <= 1'b0;
                        tx_data   <= 8'h00;
                    end
                end
                default: begin
                    tlm_state <= T_IDLE;
                    tx_valid  <= 1'b0;
                    tx_data   <= 8'h00;
                end
            endcase
            if (tlm_state != T_IDLE && tick) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// Self-checking bench for drive_cmd_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_drive_cmd_ctrl;

    localparam int NP  = 3;
    localparam int DW  = 10;
    localparam int SD  = 20;
    localparam int CTO = 100;
    localparam int TP  = 16;
    localparam int DMAX = (1 << DW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ir_valid = 1'b0;
    logic [31:0]    ir_data = 32'h0;
    logic [NP-1:0]  prox_valid = '0;
    logic [NP*DW-1:0] prox_dist = '0;
    logic [2:0]     motor_state;
    logic           blocked;
    logic           cmd_timeout;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;

    drive_cmd_ctrl #(
        .NUM_PROX    (NP),
        .DIST_W      (DW),
        .STOP_DIST   (SD),
        .CMD_TIMEOUT (CTO),
        .TLM_PERIOD  (TP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .prox_valid  (prox_valid),
        .prox_dist   (prox_dist),
        .motor_state (motor_state),
        .blocked     (blocked),
        .cmd_timeout (cmd_timeout),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [7:0] pkt [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_motor = 0;
    bit         m_blocked = 1'b0;
    bit         m_timeout = 1'b0;
    int         m_age = 0;
    int         m_min = DMAX;
    int         m_chan [NP];
    int         m_per = 0;
    bit         m_pend = 1'b0;
    logic [7:0] m_q [$];

    always @(posedge clk or negedge rst_n) begin : model
        bit         acc;
        bit         tick;
        int         nm;
        int         lo;
        logic [7:0] st;
        logic [7:0] ds;
        if (!rst_n) begin
            m_motor   = 0;
            m_blocked = 1'b0;
            m_timeout = 1'b0;
            m_age     = 0;
            m_min     = DMAX;
            for (int i = 0; i < NP; i++) m_chan[i] = DMAX;
            m_per     = 0;
            m_pend    = 1'b0;
            m_q.delete();
        end else begin
            // telemetry uses the values visible before this edge
            tick  = (m_per == TP - 1);
            m_per = tick ? 0 : m_per + 1;
            if (m_q.size() != 0) begin
                if (tick) m_pend = 1'b1;
                if (tx_ready) void'(m_q.pop_front());
            end else if (tick || m_pend) begin
                m_pend = 1'b0;
                st = {m_blocked, m_timeout, 3'b000, 3'(m_motor)};
                ds = (m_min > 255) ? 8'hFF : 8'(m_min);
                m_q.push_back(8'hA5);
                m_q.push_back(st);
                m_q.push_back(ds);
                m_q.push_back(8'hA5 ^ st ^ ds);
            end
            // motion
            acc = ir_valid && (ir_data[31:24] == ~ir_data[23:16]);
            if (acc) begin
                case (ir_data[23:16])
                    8'h02:   nm = 1;
                    8'h04:   nm = 2;
                    8'h05:   nm = 3;
                    8'h06:   nm = 4;
                    8'h08:   nm = 5;
                    default: nm = 0;
                endcase
`ifdef DRIVE_OBSTACLE_STOP_EN
                if (nm == 1 && m_blocked) nm = 3;
`endif
                m_motor   = nm;
                m_age     = 0;
                m_timeout = 1'b0;
            end else begin
                if (m_age < CTO) m_age++;
                if (m_age >= CTO) begin
                    m_timeout = 1'b1;
                    m_motor   = 0;
                end
`ifdef DRIVE_OBSTACLE_STOP_EN
                else if (m_motor == 1 && m_blocked) m_motor = 3;
`endif
            end
            // obstacle pipeline, each stage from the previous stage's old value
            m_blocked = (m_min < SD);
            lo = DMAX;
            for (int i = 0; i < NP; i++) if (m_chan[i] < lo) lo = m_chan[i];
            m_min = lo;
            for (int i = 0; i < NP; i++)
                if (prox_valid[i]) m_chan[i] = int'(prox_dist[i*DW +: DW]);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("motor_state", 32'(motor_state), 32'(m_motor));
            chk("blocked", 32'(blocked), 32'(m_blocked));
            chk("cmd_timeout", 32'(cmd_timeout), 32'(m_timeout));
            chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] key, input bit good);
        ir_data  = {good ? ~key : (~key ^ 8'h01), key, 16'($urandom)};
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
    endtask

    task automatic set_dist(input int ch, input int val);
        prox_valid[ch] = 1'b1;
        prox_dist[ch*DW +: DW] = DW'(val);
        step();
        prox_valid = '0;
    endtask

    task automatic grab();
        int g = 0;
        while (m_q.size() != 0 && g < 100) begin step(); g++; end
        while (m_q.size() != 4 && g < 200) begin step(); g++; end
        if (g >= 200) chk("pkt_wait", 32'(m_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("pkt_valid", 32'(tx_valid), 32'd1);
            pkt[k] = tx_data;
            step();
        end
    endtask

    task automatic rand_cycle(input int frame_odds);
        logic [7:0] key;
        logic [7:0] cb;
        case ($urandom_range(0, 5))
            0:       key = 8'h02;
            1:       key = 8'h04;
            2:       key = 8'h05;
            3:       key = 8'h06;
            4:       key = 8'h08;
            default: key = 8'($urandom);
        endcase
        cb = ~key;
        if ($urandom_range(0, 3) == 0) cb = cb ^ (8'h01 << $urandom_range(0, 7));
        ir_valid   = ($urandom_range(0, frame_odds - 1) == 0);
        ir_data    = {cb, key, 16'($urandom)};
        prox_valid = NP'($urandom) & NP'($urandom);
        for (int ch = 0; ch < NP; ch++)
            prox_dist[ch*DW +: DW] = ($urandom_range(0, 3) == 0) ?
                                     DW'($urandom_range(0, 40)) : DW'($urandom);
        tx_ready   = ($urandom_range(0, 9) < 7);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int hs;
        int g;

        rst_n = 1'b0;
        step(3);
        chk("rst_motor", 32'(motor_state), 32'd0);
        chk("rst_blocked", 32'(blocked), 32'd0);
        chk("rst_timeout", 32'(cmd_timeout), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(2);

        // valid and corrupted forward frames
        send_frame(8'h02, 1'b1);
        chk("fwd_frame", 32'(motor_state), 32'd1);
        send_frame(8'h02, 1'b0);
        chk("bad_frame_ignored", 32'(motor_state), 32'd1);

        // deadman: idle exactly CTO cycles after acceptance
        send_frame(8'h02, 1'b1);
        step(CTO - 2);
        chk("deadman_early", 32'(motor_state), 32'd1);
        step(1);
        chk("deadman_last", 32'(cmd_timeout), 32'd0);
        step(1);
        chk("deadman_motor", 32'(motor_state), 32'd0);
        chk("deadman_flag", 32'(cmd_timeout), 32'd1);

        // obstacle on channel 1, then forward request
        set_dist(1, 10);
        step(3);
        chk("blocked_set", 32'(blocked), 32'd1);
        send_frame(8'h02, 1'b1);
`ifdef DRIVE_OBSTACLE_STOP_EN
        chk("fwd_while_blocked", 32'(motor_state), 32'd3);
`else
        chk("fwd_while_blocked", 32'(motor_state), 32'd1);
`endif
        // blocked rising while already driving forward
        set_dist(1, 500);
        step(3);
        send_frame(8'h02, 1'b1);
        chk("fwd_clear", 32'(motor_state), 32'd1);
        set_dist(1, 5);
        step(2);
        chk("blocked_rise", 32'(blocked), 32'd1);
        step(1);
`ifdef DRIVE_OBSTACLE_STOP_EN
        chk("fwd_to_brake", 32'(motor_state), 32'd3);
`else
        chk("fwd_to_brake", 32'(motor_state), 32'd1);
`endif
        send_frame(8'h04, 1'b1);
        chk("left_blocked", 32'(motor_state), 32'd2);
        send_frame(8'h06, 1'b1);
        chk("right", 32'(motor_state), 32'd4);
        send_frame(8'h33, 1'b1);
        chk("unknown_key", 32'(motor_state), 32'd0);

        // telemetry: reverse, min distance 0x30
        tx_ready   = 1'b1;
        prox_valid = '1;
        prox_dist  = {10'h100, 10'h200, 10'h030};
        step();
        prox_valid = '0;
        send_frame(8'h08, 1'b1);
        step(3);
        grab();
        chk("pkt_rev_b0", 32'(pkt[0]), 32'hA5);
        chk("pkt_rev_b1", 32'(pkt[1]), 32'h05);
        chk("pkt_rev_b2", 32'(pkt[2]), 32'h30);
        chk("pkt_rev_b3", 32'(pkt[3]), 32'h90);

        // telemetry: brake, distance saturates above 255
        prox_valid = '1;
        prox_dist  = {10'h2F0, 10'h3FF, 10'h100};
        step();
        prox_valid = '0;
        send_frame(8'h05, 1'b1);
        step(3);
        grab();
        chk("pkt_sat_b1", 32'(pkt[1]), 32'h03);
        chk("pkt_sat_b2", 32'(pkt[2]), 32'hFF);
        chk("pkt_sat_b3", 32'(pkt[3]), 32'h59);

        // telemetry after deadman expiry
        step(CTO + 10);
        grab();
        chk("pkt_to_b1", 32'(pkt[1]), 32'h40);
        chk("pkt_to_b3", 32'(pkt[3]), 32'h1A);

        // back-pressure: header held, one pending packet follows
        g = 0;
        while (m_q.size() != 0 && g < 100) begin step(); g++; end
        tx_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx_valid) chk("stall_hdr", 32'(tx_data), 32'hA5);
        end
        chk("stall_busy", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 9; i++) begin
            if (tx_valid && tx_ready) hs++;
            step();
        end
        chk("stall_handshakes", 32'(hs), 32'd8);

        // reset in the middle of a packet
        set_dist(0, 3);
        send_frame(8'h04, 1'b1);
        step(3);
        g = 0;
        while (m_q.size() != 2 && g < 100) begin step(); g++; end
        if (g >= 100) chk("dist_wait", 32'(m_q.size()), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_motor", 32'(motor_state), 32'd0);
        chk("midrst_blocked", 32'(blocked), 32'd0);
        chk("midrst_timeout", 32'(cmd_timeout), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(TP - 1);
        chk("post_rst_quiet", 32'(tx_valid), 32'd0);
        step(1);
        chk("post_rst_start", 32'(tx_valid), 32'd1);
        chk("post_rst_hdr", 32'(tx_data), 32'hA5);

        // randomized traffic: busy commands, then sparse commands for timeouts
        for (int i = 0; i < 3000; i++) rand_cycle(20);
        for (int i = 0; i < 1500; i++) rand_cycle(200);

        ir_valid   = 1'b0;
        prox_valid = '0;
        tx_ready   = 1'b1;
        step(20);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
